// File: rtl/temp_ctrl_pkg.sv
// Shared types and constants for the temperature measurement sequencer.
package temp_ctrl_pkg;

  // Default configuration of the sequencer.
  localparam int DEF_TIMEOUT_CYCLES = 1023;
  localparam int DEF_CALC_LAT       = 2;
  localparam int DEF_PERIOD_W       = 16;

  // Datapath widths towards the ADC and the external calculator.
  localparam int TC_BASE_W = 32;
  localparam int TC_REF_W  = 8;
  localparam int ADC_W     = 16;
  localparam int TEMP_W    = 32;

  // Measurement sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CALC = 3'd3,
    ST_CAP  = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

  // Larger of two integers, used to size the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/temp_meas_timer.sv
// Loadable down-counter with a zero flag. Shared by the timeout, settle and
// gap phases; load has priority over decrement and the count saturates at 0.
module temp_meas_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise step down until empty.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/temp_measure_ctrl.sv
// Temperature measurement sequencer: triggers the ADC, waits for the sample,
// drives the external calculator and captures its result.
// Optional macro ALARM_EN enables the over-temperature alarm output.
//
// Handshake: adc_start is a one-cycle request; the ADC answers with a
// one-cycle adc_valid strobe carrying adc_data_in, accepted only in WAIT.
// temp_valid is a one-cycle pulse in the cycle temp_out takes its new value.
module temp_measure_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CALC_LAT       = DEF_CALC_LAT,
  parameter int PERIOD_W       = DEF_PERIOD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont_en,
  input  logic [PERIOD_W-1:0]  period,
  input  logic [TC_BASE_W-1:0] tc_base_in,
  input  logic [TC_REF_W-1:0]  tc_ref_in,
  output logic                 adc_start,
  input  logic                 adc_valid,
  input  logic [ADC_W-1:0]     adc_data_in,
  output logic [TC_BASE_W-1:0] calc_tc_base,
  output logic [TC_REF_W-1:0]  calc_tc_ref,
  output logic [ADC_W-1:0]     calc_adc_data,
  input  logic [TEMP_W-1:0]    calc_tempc,
  output logic [TEMP_W-1:0]    temp_out,
  output logic                 temp_valid,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic [TEMP_W-1:0]    alarm_thresh,
  output logic                 alarm
);

  localparam int CNT_W = max_int(PERIOD_W,
                                 max_int($clog2(TIMEOUT_CYCLES + 1), $clog2(CALC_LAT + 1)));

  state_e                 state_q, state_d;
  logic                   adc_start_q, adc_start_d;
  logic                   temp_valid_q, temp_valid_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   alarm_q, alarm_d;
  logic [TC_BASE_W-1:0]   calc_tc_base_q, calc_tc_base_d;
  logic [TC_REF_W-1:0]    calc_tc_ref_q, calc_tc_ref_d;
  logic [ADC_W-1:0]       calc_adc_data_q, calc_adc_data_d;
  logic [TEMP_W-1:0]      temp_out_q, temp_out_d;

  logic                   tmr_load;
  logic                   tmr_dec;
  logic [CNT_W-1:0]       tmr_load_val;
  logic                   tmr_zero;

  // One timer serves all phases: loaded with N-1 so that the state dwells
  // exactly N cycles and leaves on the cycle the timer reads zero.
  temp_meas_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state and next-output logic; outputs are registered from state_d.
  always_comb begin
    state_d         = state_q;
    timeout_err_d   = timeout_err_q;
    alarm_d         = alarm_q;
    calc_tc_base_d  = calc_tc_base_q;
    calc_tc_ref_d   = calc_tc_ref_q;
    calc_adc_data_d = calc_adc_data_q;
    temp_out_d      = temp_out_q;
    tmr_load        = 1'b0;
    tmr_dec         = 1'b0;
    tmr_load_val    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          calc_tc_base_d = tc_base_in;
          calc_tc_ref_d  = tc_ref_in;
          timeout_err_d  = 1'b0;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        tmr_load     = 1'b1;
        tmr_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A sample arriving on the last allowed cycle still counts.
        if (adc_valid) begin
          calc_adc_data_d = adc_data_in;
          tmr_load        = 1'b1;
          tmr_load_val    = CNT_W'(CALC_LAT - 1);
          state_d         = ST_CALC;
        end else if (tmr_zero) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CALC: begin
        if (tmr_zero) begin
          state_d = ST_CAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CAP: begin
        if (cont_en && (period == '0)) begin
          state_d = ST_REQ;
        end else if (cont_en) begin
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(period) - CNT_W'(1);
          state_d      = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!cont_en) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_REQ;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture happens on entry to CAP so temp_out and temp_valid line up.
    if (state_d == ST_CAP) begin
      temp_out_d = calc_tempc;
`ifdef ALARM_EN
      alarm_d    = (calc_tempc > alarm_thresh);
`endif
    end
`ifndef ALARM_EN
    alarm_d = 1'b0;
`endif

    adc_start_d  = (state_d == ST_REQ);
    temp_valid_d = (state_d == ST_CAP);
    busy_d       = (state_d != ST_IDLE);
  end

`ifndef ALARM_EN
  logic unused_alarm_thresh;
  assign unused_alarm_thresh = ^alarm_thresh;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      adc_start_q     <= 1'b0;
      temp_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      alarm_q         <= 1'b0;
      calc_tc_base_q  <= '0;
      calc_tc_ref_q   <= '0;
      calc_adc_data_q <= '0;
      temp_out_q      <= '0;
    end else begin
      state_q         <= state_d;
      adc_start_q     <= adc_start_d;
      temp_valid_q    <= temp_valid_d;
      busy_q          <= busy_d;
      timeout_err_q   <= timeout_err_d;
      alarm_q         <= alarm_d;
      calc_tc_base_q  <= calc_tc_base_d;
      calc_tc_ref_q   <= calc_tc_ref_d;
      calc_adc_data_q <= calc_adc_data_d;
      temp_out_q      <= temp_out_d;
    end
  end

  assign adc_start     = adc_start_q;
  assign temp_valid    = temp_valid_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;
  assign alarm         = alarm_q;
  assign calc_tc_base  = calc_tc_base_q;
  assign calc_tc_ref   = calc_tc_ref_q;
  assign calc_adc_data = calc_adc_data_q;
  assign temp_out      = temp_out_q;

endmodule

// File: tb/tb_temp_measure_ctrl.sv
// Bench for temp_measure_ctrl. Event cycles are predicted from the timing
// rules (start -> adc_start next cycle, capture CALC_LAT+1 after the sample,
// period gap, timeout after TIMEOUT_CYCLES waiting cycles).
module tb_temp_measure_ctrl;

  localparam int TO = 8;
  localparam int CL = 2;
  localparam int PW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          cont_en;
  logic [PW-1:0] period;
  logic [31:0]   tc_base_in;
  logic [7:0]    tc_ref_in;
  logic          adc_start;
  logic          adc_valid;
  logic [15:0]   adc_data_in;
  logic [31:0]   calc_tc_base;
  logic [7:0]    calc_tc_ref;
  logic [15:0]   calc_adc_data;
  logic [31:0]   calc_tempc;
  logic [31:0]   temp_out;
  logic          temp_valid;
  logic          busy;
  logic          timeout_err;
  logic [31:0]   alarm_thresh;
  logic          alarm;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] start_seen[$];
  logic [31:0] valid_seen[$];
  logic [31:0] temp_seen[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_temp_q[$];

  temp_measure_ctrl #(.TIMEOUT_CYCLES(TO), .CALC_LAT(CL), .PERIOD_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cont_en      (cont_en),
    .period       (period),
    .tc_base_in   (tc_base_in),
    .tc_ref_in    (tc_ref_in),
    .adc_start    (adc_start),
    .adc_valid    (adc_valid),
    .adc_data_in  (adc_data_in),
    .calc_tc_base (calc_tc_base),
    .calc_tc_ref  (calc_tc_ref),
    .calc_adc_data(calc_adc_data),
    .calc_tempc   (calc_tempc),
    .temp_out     (temp_out),
    .temp_valid   (temp_valid),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .alarm_thresh (alarm_thresh),
    .alarm        (alarm)
  );

  // Clock and cycle index
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: records when pulses appear and what was captured
  always @(negedge clk) begin
    if (adc_start === 1'b1) start_seen.push_back(32'(cyc));
    if (temp_valid === 1'b1) begin
      valid_seen.push_back(32'(cyc));
      temp_seen.push_back(temp_out);
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    start_seen.delete();
    valid_seen.delete();
    temp_seen.delete();
    exp_q.delete();
    exp_temp_q.delete();
  endtask

  function automatic bit queues_equal(input logic [31:0] a[$], input logic [31:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Driver: start a measurement now, answer adc_start after d cycles.
  // Returns r = cycle of adc_start; exits in cycle r+d+1 (first CALC cycle).
  task automatic run_shot(input logic [31:0] base, input logic [7:0] tref,
                          input logic [15:0] data, input logic [31:0] tempc,
                          input int d, input bit hold, output int r);
    tc_base_in = base;
    tc_ref_in  = tref;
    calc_tempc = tempc;
    start      = 1'b1;
    tick();
    r = cyc;
    if (!hold) start = 1'b0;
    tc_base_in = $urandom();
    tc_ref_in  = 8'($urandom());
    repeat (d) tick();
    adc_valid   = 1'b1;
    adc_data_in = data;
    tick();
    adc_valid   = 1'b0;
    adc_data_in = 16'($urandom());
    start       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (adc_start !== 1'b0) begin n_fail++; $display("FAIL reset_adc_start: got %b want 0", adc_start); end
    n_checks++; if (temp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_temp_valid: got %b want 0", temp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    n_checks++; if (temp_out !== 32'h0) begin n_fail++; $display("FAIL reset_temp_out: got %h want 0", temp_out); end
    n_checks++; if ({calc_tc_base, calc_tc_ref, calc_adc_data} !== 56'h0) begin
      n_fail++; $display("FAIL reset_calc_regs: got %h %h %h want 0", calc_tc_base, calc_tc_ref, calc_adc_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_shot();
    int r;
    clear_mon();
    run_shot(32'hAAAAAAAA, 8'hC6, 16'hAAAA, 32'h00001234, 5, 1'b0, r);
    n_checks++; if (calc_tc_base !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL shot_tc_base: got %h want aaaaaaaa", calc_tc_base); end
    n_checks++; if (calc_tc_ref !== 8'hC6) begin n_fail++; $display("FAIL shot_tc_ref: got %h want c6", calc_tc_ref); end
    n_checks++; if (calc_adc_data !== 16'hAAAA) begin n_fail++; $display("FAIL shot_adc_data: got %h want aaaa", calc_adc_data); end
    repeat (CL) tick();
    n_checks++; if (temp_valid !== 1'b1) begin n_fail++; $display("FAIL shot_temp_valid: got %b want 1 at cycle %0d", temp_valid, cyc); end
    n_checks++; if (temp_out !== 32'h00001234) begin n_fail++; $display("FAIL shot_temp_out: got %h want 00001234", temp_out); end
    tick();
    n_checks++; if ({busy, temp_valid} !== 2'b00) begin n_fail++; $display("FAIL shot_after: busy/temp_valid got %b%b want 00", busy, temp_valid); end
    tick();
    exp_q.push_back(32'(r + 5 + CL + 1));
    n_checks++; if (!queues_equal(valid_seen, exp_q)) begin
      n_fail++; $display("FAIL shot_valid_timing: got %0d pulses, want one at cycle %0d", valid_seen.size(), exp_q[0]);
    end
    n_checks++; if (start_seen.size() != 1) begin n_fail++; $display("FAIL shot_adc_start_count: got %0d want 1", start_seen.size()); end
  endtask

  task automatic test_random_shots();
    int r, d;
    bit hold;
    logic [31:0] base, tempc;
    logic [7:0]  tref;
    logic [15:0] data;
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      base = $urandom(); tref = 8'($urandom()); data = 16'($urandom()); tempc = $urandom();
      d = $urandom_range(1, TO);
      hold = 1'($urandom_range(0, 1));
      run_shot(base, tref, data, tempc, d, hold, r);
      exp_q.push_back(32'(r + d + CL + 1));
      exp_temp_q.push_back(tempc);
      repeat (CL) tick();
      n_checks++; if ({calc_tc_base, calc_tc_ref, calc_adc_data} !== {base, tref, data}) begin
        n_fail++; $display("FAIL rand_calc_regs[%0d]: got %h %h %h want %h %h %h", i,
                           calc_tc_base, calc_tc_ref, calc_adc_data, base, tref, data);
      end
      n_checks++; if ({temp_valid, temp_out} !== {1'b1, tempc}) begin
        n_fail++; $display("FAIL rand_capture[%0d]: got valid=%b temp=%h want valid=1 temp=%h (d=%0d)", i, temp_valid, temp_out, tempc, d);
      end
      tick();
      n_checks++; if ({busy, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL rand_idle[%0d]: busy/err got %b%b want 00", i, busy, timeout_err); end
    end
    tick();
    n_checks++; if (!queues_equal(valid_seen, exp_q) || !queues_equal(temp_seen, exp_temp_q)) begin
      n_fail++; $display("FAIL rand_scoreboard: got %0d captures want %0d", valid_seen.size(), exp_q.size());
    end
    n_checks++; if (start_seen.size() != 6) begin n_fail++; $display("FAIL rand_adc_start_count: got %0d want 6", start_seen.size()); end
  endtask

  task automatic test_timeout();
    int r, r2;
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (TO) tick();
    n_checks++; if ({busy, timeout_err} !== 2'b10) begin n_fail++; $display("FAIL timeout_last_wait: busy/err got %b%b want 10", busy, timeout_err); end
    tick();
    n_checks++; if ({busy, timeout_err} !== 2'b01) begin n_fail++; $display("FAIL timeout_flag: busy/err got %b%b want 01", busy, timeout_err); end
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (timeout_err !== 1'b1 || valid_seen.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sticky: err=%b captures=%0d busy=%b want 1 0 0", timeout_err, valid_seen.size(), busy);
    end
    run_shot($urandom(), 8'($urandom()), 16'h1111, 32'h2222, 1, 1'b0, r2);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    repeat (CL + 1) tick();
    r = r2;
  endtask

  task automatic test_valid_at_timeout();
    int r;
    clear_mon();
    run_shot($urandom(), 8'($urandom()), 16'h5A5A, 32'hCAFE0001, TO, 1'b0, r);
    n_checks++; if ({busy, timeout_err, calc_adc_data} !== {2'b10, 16'h5A5A}) begin
      n_fail++; $display("FAIL edge_valid: busy/err/data got %b%b %h want 10 5a5a", busy, timeout_err, calc_adc_data);
    end
    repeat (CL) tick();
    n_checks++; if ({temp_valid, temp_out} !== {1'b1, 32'hCAFE0001}) begin
      n_fail++; $display("FAIL edge_capture: got valid=%b temp=%h want 1 cafe0001", temp_valid, temp_out);
    end
    tick();
  endtask

  task automatic test_continuous();
    int r, d, p, guard, pred;
    logic [31:0] base0, tempc;
    clear_mon();
    cont_en = 1'b1;
    period  = 16'd4;
    base0   = $urandom();
    tc_base_in = base0;
    start = 1'b1;
    tick();
    start = 1'b0;
    pred = 0;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (adc_start !== 1'b1 && guard < 64) begin tick(); guard++; end
      n_checks++;
      if (guard >= 64) begin
        n_fail++; $display("FAIL cont_wait_adc_start[%0d]: no adc_start within 64 cycles", k);
        break;
      end
      r = cyc;
      if (k > 0 && r != pred) begin n_fail++; $display("FAIL cont_interval[%0d]: adc_start at %0d want %0d", k, r, pred); end
      d = (k == 0) ? 2 : $urandom_range(1, 4);
      p = (k == 0) ? 4 : $urandom_range(1, 5);
      tempc = $urandom();
      tc_base_in = $urandom();
      repeat (d) tick();
      adc_valid = 1'b1; adc_data_in = 16'($urandom()); calc_tempc = tempc; period = PW'(p);
      tick();
      adc_valid = 1'b0;
      exp_temp_q.push_back(tempc);
      pred = r + d + CL + p + 2;
      if (k == 3) begin
        repeat (CL) tick();
        tick();
        cont_en = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop: busy got %b want 0", busy); end
      end
    end
    cont_en = 1'b0;
    repeat (20) tick();
    n_checks++; if (start_seen.size() != 4) begin n_fail++; $display("FAIL cont_adc_start_count: got %0d want 4", start_seen.size()); end
    n_checks++; if (!queues_equal(temp_seen, exp_temp_q)) begin n_fail++; $display("FAIL cont_temps: got %0d captures want %0d", temp_seen.size(), exp_temp_q.size()); end
    n_checks++; if (calc_tc_base !== base0) begin n_fail++; $display("FAIL cont_no_relatch: got %h want %h", calc_tc_base, base0); end
  endtask

  task automatic test_period_zero();
    int r;
    clear_mon();
    cont_en = 1'b1;
    period  = '0;
    run_shot($urandom(), 8'($urandom()), 16'h0F0F, 32'h0BAD0BAD, 1, 1'b0, r);
    repeat (CL) tick();
    n_checks++; if (temp_valid !== 1'b1) begin n_fail++; $display("FAIL p0_capture: temp_valid got %b want 1", temp_valid); end
    tick();
    n_checks++; if ({adc_start, temp_valid} !== 2'b10) begin n_fail++; $display("FAIL p0_restart: adc_start/temp_valid got %b%b want 10", adc_start, temp_valid); end
    cont_en = 1'b0;
    tick();
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (CL) tick();
    tick();
    n_checks++; if ({busy, adc_start} !== 2'b00) begin n_fail++; $display("FAIL p0_stop: busy/adc_start got %b%b want 00", busy, adc_start); end
  endtask

  task automatic test_reset_mid_calc();
    int r;
    clear_mon();
    run_shot(32'h13572468, 8'h9B, 16'h7777, 32'h0000ABCD, 2, 1'b0, r);
    rst = 1'b1;
    tick();
    n_checks++; if ({adc_start, temp_valid, busy, timeout_err, alarm} !== 5'b0 || temp_out !== 32'h0 ||
                    {calc_tc_base, calc_tc_ref, calc_adc_data} !== 56'h0) begin
      n_fail++; $display("FAIL midreset_outputs: flags=%b%b%b%b%b temp=%h calc=%h %h %h want all 0",
                         adc_start, temp_valid, busy, timeout_err, alarm, temp_out, calc_tc_base, calc_tc_ref, calc_adc_data);
    end
    rst = 1'b0;
    adc_valid = 1'b1;
    adc_data_in = 16'hBEEF;
    tick();
    adc_valid = 1'b0;
    repeat (8) tick();
    n_checks++; if (busy !== 1'b0 || calc_adc_data !== 16'h0 || valid_seen.size() != 0 || start_seen.size() != 1) begin
      n_fail++; $display("FAIL midreset_late_valid: busy=%b data=%h captures=%0d starts=%0d want 0 0 0 1",
                         busy, calc_adc_data, valid_seen.size(), start_seen.size());
    end
  endtask

  task automatic test_alarm();
    int r;
    logic [31:0] tempc, thr;
    bit exp_alarm;
    for (int i = 0; i < 6; i++) begin
      thr = (i < 2) ? 32'h1000 : $urandom();
      tempc = (i == 0) ? 32'h1001 : (i == 1) ? 32'h1000 : (i == 2) ? thr + 32'd1 : $urandom();
      alarm_thresh = thr;
`ifdef ALARM_EN
      exp_alarm = (tempc > thr);
`else
      exp_alarm = 1'b0;
`endif
      run_shot($urandom(), 8'($urandom()), 16'($urandom()), tempc, 1, 1'b0, r);
      repeat (CL) tick();
      n_checks++; if (alarm !== exp_alarm) begin
        n_fail++; $display("FAIL alarm[%0d]: got %b want %b (tempc=%h thresh=%h)", i, alarm, exp_alarm, tempc, thr);
      end
      alarm_thresh = ~thr;
      tick();
      n_checks++; if (alarm !== exp_alarm) begin n_fail++; $display("FAIL alarm_hold[%0d]: got %b want %b", i, alarm, exp_alarm); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont_en = 1'b0; period = '0;
    tc_base_in = '0; tc_ref_in = '0; adc_valid = 1'b0; adc_data_in = '0;
    calc_tempc = '0; alarm_thresh = '0;
    test_reset();
    test_single_shot();
    test_random_shots();
    test_timeout();
    test_valid_at_timeout();
    test_continuous();
    test_period_zero();
    test_alarm();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
